uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver and successor to the fixed 8N1 receive path in uart. It oversamples the rxd pin with majority voting and supports 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. Each received character is buffered in an internal FIFO together with per-character error flags, and the FIFO is drained through a valid/ready read port. It sits between the board RXD pin and the uart_rd_* consumer.

Parameters:
CLK_FREQ, 100000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, samples per bit; even, >=8
FIFO_DEPTH, 16, RX FIFO entries; power of 2, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
uart_rxd  in  1  asynchronous serial input, idle high
cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  2  00/11=none, 01=even, 10=odd
cfg_stop2  in  1  1 = two stop bits expected
uart_rd_data  out  8  received character, right-aligned, unused MSBs 0
uart_rd_frame_err  out  1  framing error for the head character
uart_rd_parity_err  out  1  parity error for the head character
uart_rd_valid  out  1  FIFO not empty
uart_rd_ready  in  1  consumer accepts the head entry
rx_busy  out  1  frame in progress (state != IDLE)
break_det  out  1  one-cycle pulse when a break is detected
overrun  out  1  sticky flag: a character was dropped because the FIFO was full
err_clr  in  1  clears overrun
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently held

Behaviour:
- Reset values: uart_rd_valid=0, uart_rd_data=0, both error outputs=0, rx_busy=0, break_det=0, overrun=0, fifo_count=0. The synchroniser flops reset to 1. The FSM resets to IDLE.
- Reset asserted mid-frame aborts the frame and flushes the FIFO.
- rxd passes through a 2-flop synchroniser before any other logic.
- Tick generator: tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, using integer division. The counter resets on start-edge detection so bit timing is aligned to the edge.
- Sample value = majority of the synchronised rxd at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit.
- FSM:
  - IDLE -> START on a 1->0 transition of the synchronised rxd.
  - START: a sample of 1 is a glitch and returns to IDLE with no push and no flag. A sample of 0 latches the cfg_* inputs and moves to DATA. cfg changes mid-frame have no effect.
  - DATA: shifts in N data bits, LSB first.
  - DATA -> PARITY if parity is enabled, else -> STOP.
  - PARITY: parity_err = (XOR of data bits XOR parity bit) != (odd ? 1 : 0).
  - STOP: each stop bit is sampled; any 0 sets frame_err. With cfg_stop2=1 both stop bits are checked.
  - The result is written at the final stop-bit sample tick and the FSM returns to IDLE on the same cycle, so a start edge during the remainder of the stop bit is accepted.
- Break: all data bits 0, parity bit (if present) 0 and first stop sample 0. On a break, break_det pulses and nothing is pushed. The FSM then waits in IDLE-hold until rxd is sampled 1 before detecting a new start edge.
- FIFO:
  - Entry = {parity_err, frame_err, data}.
  - Pop on uart_rd_valid & uart_rd_ready.
  - Read data is combinational from the head; the first-word latency from the write is 1 clock.
  - A push when full with no pop in the same cycle drops the character and sets overrun.
  - A push and pop in the same cycle when full both succeed and the count stays at FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- err_clr clears overrun. If err_clr and a new overrun occur in the same cycle, overrun stays set.

Test Plan:
- Bench parameters for all cases: CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and one bit is 160 clocks.
- 8N1, send 0xA5 with uart_rd_ready=1 -> one pop with data=0xA5 and both errors 0. uart_rd_valid rises within 2 clocks of the stop mid-sample. rx_busy is high for about 9.5 bit times.
- 7E2, send 0x35 with correct even parity -> data=0x35 and parity_err=0. Resend with the parity bit flipped -> data=0x35 and parity_err=1. 5O1, send 0x1F -> data=0x1F with bits 7:5 = 0.
- Stop bit driven 0 with data 0x41 -> data=0x41 and frame_err=1. rxd held low for 20 bit times (break) -> break_det pulses once, no push, and the next 0x55 is received cleanly.
- 40-clock low glitch on idle rxd -> no push and rx_busy returns to 0 within 1 bit time. Toggle cfg_data_bits mid-frame -> the frame is still decoded with the latched config.
- uart_rd_ready=0, send 17 characters (0x00..0x10) -> fifo_count=16 and overrun=1. Draining yields 0x00..0x0F in order, 0x10 is lost, and err_clr clears overrun.
- Full FIFO with a pop in the same cycle as a push -> no overrun and count stays 16. Assert rst mid-frame -> all outputs return to reset values and the next frame is decoded correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with majority-vote
// oversampling, 5..8 data bits, none/even/odd parity, 1 or 2 stop bits,
// break detection and an RX FIFO drained through a valid/ready read port.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   uart_rxd              asynchronous serial input (idle high)
//   cfg_data_bits         00=5, 01=6, 10=7, 11=8 data bits
//   cfg_parity            00/11=none, 01=even, 10=odd
//   cfg_stop2             1 = two stop bits expected
//   uart_rd_data          head character, right-aligned, unused MSBs 0
//   uart_rd_frame_err     framing error flag of the head character
//   uart_rd_parity_err    parity error flag of the head character
//   uart_rd_valid         FIFO not empty
//   uart_rd_ready         consumer accepts the head entry
//   rx_busy               frame in progress
//   break_det             one-cycle pulse on a detected break
//   overrun               sticky: a character was dropped on a full FIFO
//   err_clr               clears overrun
//   fifo_count            entries currently held
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_rxd,
    input  logic [1:0]                        cfg_data_bits,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    output logic [7:0]                        uart_rd_data,
    output logic                              uart_rd_frame_err,
    output logic                              uart_rd_parity_err,
    output logic                              uart_rd_valid,
    input  logic                              uart_rd_ready,
    output logic                              rx_busy,
    output logic                              break_det,
    output logic                              overrun,
    input  logic                              err_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned DIV     = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_HOLD
    } state_e;

    // ---------------- synchroniser and edge detect ----------------
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    state_e state_q, state_d;
    logic   start_edge_c;

    assign start_edge_c = (state_q == S_IDLE) && prev_q && !sync2_q;

    // ---------------- oversample tick generator ----------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [OS_W-1:0]  os_cnt_q;
    logic             tick_c;
    logic             sample_c;
    logic             vote1_q, vote2_q;
    logic             maj_c;

    assign tick_c   = (div_cnt_q == DIV_W'(DIV - 1));
    assign sample_c = tick_c && (os_cnt_q == OS_W'(OVERSAMPLE / 2 + 1));
    assign maj_c    = (vote1_q & vote2_q) | (vote1_q & sync2_q) | (vote2_q & sync2_q);

    // Restarting on the start edge aligns every bit window to that edge.
    always_ff @(posedge clk) begin
        if (rst || start_edge_c) begin
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
        end else if (tick_c) begin
            div_cnt_q <= '0;
            os_cnt_q  <= (os_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OS_W'(1);
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // First two of the three majority samples; the third is live rxd.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote1_q <= 1'b1;
            vote2_q <= 1'b1;
        end else if (tick_c) begin
            if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) vote1_q <= sync2_q;
            if (os_cnt_q == OS_W'(OVERSAMPLE / 2))     vote2_q <= sync2_q;
        end
    end

    // ---------------- receive FSM ----------------
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic [7:0] data_q, data_d;
    logic       par_bit_q, par_bit_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] nbits_q, nbits_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;
    logic       stop2_q, stop2_d;
    logic       break_q, break_d;
    logic       push_c;
    logic       push_fe_c;
    logic       par_err_c;
    rx_entry_t  push_entry_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            data_q      <= '0;
            par_bit_q   <= 1'b0;
            frame_err_q <= 1'b0;
            nbits_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            data_q      <= data_d;
            par_bit_q   <= par_bit_d;
            frame_err_q <= frame_err_d;
            nbits_q     <= nbits_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            stop2_q     <= stop2_d;
            break_q     <= break_d;
        end
    end

    // Parity check over the received data plus the parity bit.
    assign par_err_c = par_en_q && ((^data_q ^ par_bit_q) != par_odd_q);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        data_d      = data_q;
        par_bit_d   = par_bit_q;
        frame_err_d = frame_err_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        stop2_d     = stop2_q;
        break_d     = 1'b0;
        push_c      = 1'b0;
        push_fe_c   = frame_err_q | ~maj_c;

        case (state_q)
            S_IDLE: begin
                if (start_edge_c) state_d = S_START;
            end
            S_START: begin
                if (sample_c) begin
                    if (maj_c) begin
                        state_d = S_IDLE;
                    end else begin
                        // Configuration is frozen for the rest of the frame.
                        nbits_d     = cfg_data_bits;
                        par_en_d    = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        par_odd_d   = (cfg_parity == 2'b10);
                        stop2_d     = cfg_stop2;
                        data_d      = '0;
                        bit_cnt_d   = '0;
                        stop_cnt_d  = 1'b0;
                        par_bit_d   = 1'b0;
                        frame_err_d = 1'b0;
                        state_d     = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (sample_c) begin
                    data_d[bit_cnt_q] = maj_c;
                    if (bit_cnt_q == (3'(nbits_q) + 3'd4)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample_c) begin
                    par_bit_d = maj_c;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (sample_c) begin
                    if (!stop_cnt_q && (data_q == 8'h00) && !(par_en_q && par_bit_q) && !maj_c) begin
                        // Break: line low through data, parity and first stop.
                        break_d = 1'b1;
                        state_d = S_HOLD;
                    end else if (stop2_q && !stop_cnt_q) begin
                        frame_err_d = push_fe_c;
                        stop_cnt_d  = 1'b1;
                    end else begin
                        push_c  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push_entry_c = '{parity_err: par_err_c, frame_err: push_fe_c, data: data_q};

    assign rx_busy   = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign break_det = break_q;

    // ---------------- RX FIFO ----------------
    rx_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             overrun_q;
    logic             full_c, pop_c, push_ok_c, drop_c;
    rx_entry_t        head_c;

    assign full_c    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop_c     = uart_rd_valid && uart_rd_ready;
    assign push_ok_c = push_c && (!full_c || pop_c);
    assign drop_c    = push_c && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= push_entry_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok_c && !pop_c)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!push_ok_c && pop_c) cnt_q <= cnt_q - CNT_W'(1);
            // A new drop wins over a simultaneous clear.
            if (drop_c)       overrun_q <= 1'b1;
            else if (err_clr) overrun_q <= 1'b0;
        end
    end

    assign head_c             = mem_q[rd_ptr_q];
    assign uart_rd_valid      = (cnt_q != '0);
    assign uart_rd_data       = uart_rd_valid ? head_c.data : 8'h00;
    assign uart_rd_frame_err  = uart_rd_valid && head_c.frame_err;
    assign uart_rd_parity_err = uart_rd_valid && head_c.parity_err;
    assign overrun            = overrun_q;
    assign fifo_count         = cnt_q;

endmodule
